output_layer_ctrl: RTL and testbench
====================================

OUTPUT_LAYER_CTRL -- requirements
Module: output_layer_ctrl

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 10, meaning the number of output neurons and bias ROM entries.
REQ-002 SHALL have parameter ACC_W, default 16, meaning the width of the signed accumulator and sum.
REQ-003 SHALL have parameter BIAS_W, default 8, meaning the width of the signed bias word.
REQ-004 SHALL have ports: clk_i  in  1  sole clock, rising edge.
REQ-005 SHALL have ports: rst_ni  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: start_i  in  1  single-cycle request to process one output layer.
REQ-007 SHALL have ports: rom_addr_o  out  4  address to the bias ROM, which has 1-cycle registered read latency.
REQ-008 SHALL have ports: bias_i  in  BIAS_W  signed bias returned by the ROM.
REQ-009 SHALL have ports: acc_valid_i / acc_ready_o  in/out  1  handshake for the accumulator stream, one word per neuron in index order.
REQ-010 SHALL have ports: acc_i  in  ACC_W  signed accumulator value for the current neuron.
REQ-011 SHALL have ports: sum_valid_o / sum_ready_i  out/in  1  handshake for biased results.
REQ-012 SHALL have ports: sum_o  out  ACC_W  signed saturated acc+bias.
REQ-013 SHALL have ports: busy_o  out  1  high in any state other than IDLE.
REQ-014 SHALL have ports: done_o  out  1  one-cycle pulse at layer completion.
REQ-015 SHALL have ports: class_o  out  4  argmax neuron index, valid from done_o until the next start.

Function
REQ-016 SHALL implement the FSM states IDLE, FETCH, ADD, OUT and DONE.
REQ-017 IDLE: when start_i=1, SHALL clear idx to 0, clear the running max, and go to FETCH; start_i SHALL be ignored in every other state.
REQ-018 rom_addr_o SHALL equal the idx register combinationally in all states.
REQ-019 FETCH SHALL last exactly 1 cycle (covering ROM latency) and then go to ADD.
REQ-020 ADD: acc_ready_o SHALL be 1 in ADD only.
REQ-021 ADD: on acc_valid_i&acc_ready_o, SHALL register sum = sat(acc_i + sext(bias_i)) and go to OUT; otherwise it SHALL stay in ADD.
REQ-022 Saturation SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1], computed at ACC_W+1 bits.
REQ-023 OUT: sum_valid_o SHALL be 1 with sum_o stable until sum_ready_i=1.
REQ-024 OUT: on the handshake, if sum > max or idx==0, SHALL set max=sum and class=idx (ties keep the lower index).
REQ-025 OUT: after the handshake, if idx==NUM_NEURONS-1 it SHALL go to DONE, else idx++ and go to FETCH.
REQ-026 DONE SHALL assert done_o for exactly 1 cycle, then go to IDLE.
REQ-027 Minimum per-neuron latency, with valid/ready held high, SHALL be 3 cycles (FETCH, ADD, OUT); a full layer SHALL take 3*NUM_NEURONS+1 cycles from start to done.
REQ-028 idx SHALL never exceed NUM_NEURONS-1, with no wrap-around.

Reset
REQ-029 Asserting rst_ni=0 SHALL immediately force state=IDLE, idx=0, sum=0, max=0 and class=0.
REQ-030 During reset all outputs SHALL be 0: acc_ready_o, sum_valid_o, busy_o, done_o, class_o, sum_o and rom_addr_o.
REQ-031 Reset mid-layer SHALL abandon the layer with no done_o pulse; a new start_i SHALL be required.
REQ-032 Deassertion SHALL be taken synchronously to clk_i; the first start_i SHALL be accepted on the first edge after release.

Structure
REQ-033 NUM_NEURONS, ACC_W, BIAS_W defaults and the state enum SHALL reside in the shared package nn_pkg.
REQ-034 Saturating add SHALL be a sub-module sat_add (combinational, parameterised widths).
REQ-035 The bias ROM SHALL remain external, connected via rom_addr_o/bias_i.

Verification
REQ-036 Biases 0..9 = 0x01..0x0A, acc = 100 for all, handshakes always ready -> sums 101..110, class_o=9, done_o at cycle 31 after start.
REQ-037 acc_i=0x7FF0, bias=0x7F -> sum_o=0x7FFF; acc_i=0x8005, bias=0x80 -> sum_o=0x8000.
REQ-038 Equal sums 50 at idx 2 and idx 7, all others lower -> class_o=2.
REQ-039 Hold sum_ready_i=0 for 5 cycles in OUT for idx 4 -> sum_o stable, idx stays 4, acc_ready_o=0 throughout.
REQ-040 Drop rst_ni at idx 5 in ADD -> all outputs 0 the same cycle, no done_o, next start restarts at idx 0.
REQ-041 start_i pulsed while busy -> ignored, with layer count and done timing unchanged.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared defaults and FSM encoding for the output-layer controller slice.
package nn_pkg;
  localparam int DEF_NUM_NEURONS = 10;
  localparam int DEF_ACC_W       = 16;
  localparam int DEF_BIAS_W      = 8;
  localparam int IDX_W           = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ADD   = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/output_layer_ctrl_if.sv
// Accumulator-in / biased-sum-out handshake bundle of the output-layer controller.
interface output_layer_ctrl_if
  import nn_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
);
  logic                    acc_valid_i;
  logic                    acc_ready_o;
  logic signed [ACC_W-1:0] acc_i;
  logic                    sum_valid_o;
  logic                    sum_ready_i;
  logic signed [ACC_W-1:0] sum_o;

  // slave is the controller side, master is the producer/consumer around it
  modport slave  (input  acc_valid_i, acc_i, sum_ready_i,
                  output acc_ready_o, sum_valid_o, sum_o);
  modport master (output acc_valid_i, acc_i, sum_ready_i,
                  input  acc_ready_o, sum_valid_o, sum_o);
endinterface

// File: rtl/output_layer_ctrl_sat_add.sv
// Combinational signed add of a narrow bias onto a wide accumulator, clamped to A_W bits.
module sat_add #(
  parameter int A_W = 16,
  parameter int B_W = 8
) (
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  output logic signed [A_W-1:0] y
);
  function automatic logic signed [A_W-1:0] sat(input logic signed [A_W:0] v);
    logic signed [A_W-1:0] r;
    if (v[A_W] != v[A_W-1])
      r = v[A_W] ? {1'b1, {(A_W-1){1'b0}}} : {1'b0, {(A_W-1){1'b1}}};
    else
      r = v[A_W-1:0];
    return r;
  endfunction

  logic signed [A_W:0] wide;

  // one guard bit is enough: the bias never exceeds the accumulator width
  assign wide = $signed({a[A_W-1], a}) + $signed({{(A_W+1-B_W){b[B_W-1]}}, b});
  assign y    = sat(wide);
endmodule

// File: rtl/output_layer_ctrl.sv
// Walks the output neurons: fetch bias, add to accumulator, emit sum, track argmax.
module output_layer_ctrl
  import nn_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int BIAS_W      = DEF_BIAS_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  output logic [IDX_W-1:0]         rom_addr_o,
  input  logic signed [BIAS_W-1:0] bias_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [IDX_W-1:0]         class_o,
  output_layer_ctrl_if.slave       bus
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W-1:0]        class_q;
  logic signed [ACC_W-1:0] sum_q;
  logic signed [ACC_W-1:0] max_q;
  logic signed [ACC_W-1:0] sat_sum;
  logic                    acc_ready;
  logic                    sum_valid;

  sat_add #(.A_W(ACC_W), .B_W(BIAS_W)) u_sat_add (
    .a (bus.acc_i),
    .b (bias_i),
    .y (sat_sum)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    acc_ready = 1'b0;
    sum_valid = 1'b0;
    done_o    = 1'b0;
    busy_o    = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_FETCH;
      // the ROM read issued with this idx lands in bias_i by ADD
      S_FETCH: state_d = S_ADD;
      S_ADD: begin
        acc_ready = 1'b1;
        if (bus.acc_valid_i) state_d = S_OUT;
      end
      S_OUT: begin
        sum_valid = 1'b1;
        if (bus.sum_ready_i) state_d = (idx_q == LAST_IDX) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      class_q <= '0;
    end else begin
      if (state_q == S_IDLE && start_i) begin
        idx_q <= '0;
        max_q <= '0;
      end
      if (state_q == S_ADD && bus.acc_valid_i) sum_q <= sat_sum;
      if (state_q == S_OUT && bus.sum_ready_i) begin
        // strict compare keeps the lower index on ties
        if (sum_q > max_q || idx_q == '0) begin
          max_q   <= sum_q;
          class_q <= idx_q;
        end
        if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign rom_addr_o      = idx_q;
  assign class_o         = class_q;
  assign bus.acc_ready_o = acc_ready;
  assign bus.sum_valid_o = sum_valid;
  assign bus.sum_o       = sum_q;
endmodule

// File: tb/tb_output_layer_ctrl.sv
// Directed bench for output_layer_ctrl with a registered bias ROM model.
module tb_output_layer_ctrl;
  logic              clk;
  logic              rst_n;
  logic              start;
  logic [3:0]        rom_addr;
  logic signed [7:0] bias = '0;
  logic              busy;
  logic              done;
  logic [3:0]        cls;

  logic signed [7:0]  rom_tab [16];
  logic signed [15:0] acc_tab [16];
  logic [15:0]        got     [16];
  logic [15:0]        hold_val;

  int total = 0;
  int bad   = 0;

  output_layer_ctrl_if #(.ACC_W(16)) bus ();

  output_layer_ctrl #(.NUM_NEURONS(10), .ACC_W(16), .BIAS_W(8)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .rom_addr_o (rom_addr),
    .bias_i     (bias),
    .busy_o     (busy),
    .done_o     (done),
    .class_o    (cls),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bias <= rom_tab[rom_addr];

  assign bus.acc_i = acc_tab[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_sum(input int n);
    int v;
    v = int'(acc_tab[n]) + int'(rom_tab[n]);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_acc_ready"}, {31'd0, bus.acc_ready_o}, 32'd0);
    check({tag, "_sum_valid"}, {31'd0, bus.sum_valid_o}, 32'd0);
    check({tag, "_busy"},      {31'd0, busy},            32'd0);
    check({tag, "_done"},      {31'd0, done},            32'd0);
    check({tag, "_class"},     {28'd0, cls},             32'd0);
    check({tag, "_sum"},       {16'd0, bus.sum_o},       32'd0);
    check({tag, "_rom_addr"},  {28'd0, rom_addr},        32'd0);
  endtask

  // hold_idx: neuron whose OUT is stalled 5 cycles (-1 none); spur_cyc: cycle of a stray start (0 none)
  task automatic run_layer(input int hold_idx, input int spur_cyc, output int cycles, output int nsum);
    int held;
    bit fin;
    held = 0; nsum = 0; cycles = 0; fin = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    cycles = 1;
    while (!fin && cycles < 200) begin
      @(negedge clk);
      start = (cycles == spur_cyc);
      if (cycles == 1) check("first_idx", {28'd0, rom_addr}, 32'd0);
      if (done) fin = 1;
      else begin
        if (bus.sum_valid_o) begin
          if (nsum == hold_idx && held < 5) begin
            bus.sum_ready_i = 1'b0;
            if (held == 0) hold_val = bus.sum_o;
            else check("hold_sum", {16'd0, bus.sum_o}, {16'd0, hold_val});
            check("hold_idx", {28'd0, rom_addr}, 32'(hold_idx));
            check("hold_acc_ready", {31'd0, bus.acc_ready_o}, 32'd0);
            held++;
          end else begin
            bus.sum_ready_i = 1'b1;
            check("sum", {16'd0, bus.sum_o}, {16'd0, exp_sum(nsum)});
            got[nsum] = bus.sum_o;
            nsum++;
          end
        end
        @(posedge clk);
        cycles++;
      end
    end
    start = 1'b0;
    if (!fin) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cyc, ns, guard, dcount;
    for (int i = 0; i < 16; i++) begin
      rom_tab[i] = '0;
      acc_tab[i] = '0;
      got[i]     = '0;
    end
    rst_n = 1'b0;
    start = 1'b0;
    bus.acc_valid_i = 1'b1;
    bus.sum_ready_i = 1'b1;
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // layer 1: biases 1..10 on acc 100
    for (int i = 0; i < 10; i++) begin
      rom_tab[i] = 8'(i + 1);
      acc_tab[i] = 16'sd100;
    end
    run_layer(-1, 0, cyc, ns);
    check("l1_cycles", 32'(cyc), 32'd31);
    check("l1_nsum",   32'(ns),  32'd10);
    check("l1_sum0",   {16'd0, got[0]}, 32'd101);
    check("l1_sum9",   {16'd0, got[9]}, 32'd110);
    check("l1_class",  {28'd0, cls},    32'd9);
    check("l1_class_held", {28'd0, cls}, 32'd9);

    // layer 2: tie at 50 on neurons 2 and 7
    for (int i = 0; i < 10; i++) rom_tab[i] = '0;
    acc_tab[0] = 16'sd10; acc_tab[1] = 16'sd20; acc_tab[2] = 16'sd50; acc_tab[3] = 16'sd30;
    acc_tab[4] = 16'sd40; acc_tab[5] = 16'sd5;  acc_tab[6] = 16'sd6;  acc_tab[7] = 16'sd50;
    acc_tab[8] = 16'sd1;  acc_tab[9] = 16'sd2;
    run_layer(-1, 0, cyc, ns);
    check("tie_class", {28'd0, cls}, 32'd2);
    check("tie_sum7",  {16'd0, got[7]}, 32'd50);

    // layer 3: saturation at both rails
    for (int i = 0; i < 10; i++) acc_tab[i] = '0;
    rom_tab[0] = 8'sh7F; acc_tab[0] = 16'sh7FF0;
    rom_tab[1] = 8'sh80; acc_tab[1] = 16'sh8005;
    rom_tab[2] = 8'sh80; acc_tab[2] = 16'sh0010;
    run_layer(-1, 0, cyc, ns);
    check("sat_pos", {16'd0, got[0]}, 32'h7FFF);
    check("sat_neg", {16'd0, got[1]}, 32'h8000);
    check("neg_bias", {16'd0, got[2]}, 32'hFF90);
    check("sat_class", {28'd0, cls}, 32'd0);

    // layer 4: stall at idx 4 for 5 cycles plus a stray start mid-layer
    for (int i = 0; i < 10; i++) begin
      rom_tab[i] = 8'(i + 1);
      acc_tab[i] = 16'sd100;
    end
    acc_tab[3] = 16'sd500;
    run_layer(4, 10, cyc, ns);
    check("stall_cycles", 32'(cyc), 32'd36);
    check("stall_nsum",   32'(ns),  32'd10);
    check("stall_class",  {28'd0, cls}, 32'd3);

    // layer 5: reset while idx 5 is in ADD
    acc_tab[3] = 16'sd100;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(rom_addr == 4'd5 && bus.acc_ready_o) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("reach_add5", {31'd0, (guard < 100)}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("no_done_after_rst", 32'(dcount), 32'd0);
    check("idle_after_rst", {31'd0, busy}, 32'd0);
    run_layer(-1, 0, cyc, ns);
    check("post_rst_cycles", 32'(cyc), 32'd31);
    check("post_rst_class",  {28'd0, cls}, 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
